fetch_stage: RTL and testbench

// - Instruction-fetch stage: owns the PC, issues instruction-memory requests, and loads the IF/ID pipeline register.
// - Produces the pc_plus_2 consumed by the branch-control logic.
// - Consumes the branch-control decision (taken + target) to redirect fetch and squash wrong-path instructions.
// - Stops fetching on the HALT opcode until a redirect or reset.

---
 rtl/fetch_stage_pkg.sv | 10 +
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage_cla.sv | 26 ++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants, state encoding and opcode helper for the fetch stage
package fetch_stage_pkg;
    localparam int INSTR_W = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [3:0] HALT_OPC = 4'hF;
    typedef enum logic [1:0] {FETCH, DRAIN, HOLD, HALT} state_t;
    function automatic logic is_halt(input logic [INSTR_W-1:0] instr, input logic [3:0] opc);
        return instr[INSTR_W-1 -: 4] == opc;
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/acknowledge bus
interface fetch_stage_if;
    import fetch_stage_pkg::*;
    logic req;
    logic [15:0] addr;
    logic ack;
    logic [INSTR_W-1:0] rdata;
    modport master(output req, addr, input ack, rdata);
    modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_stage_cla.sv
// fetch_stage_cla: 16-bit carry-lookahead adder/subtractor built from 4-bit lookahead groups
module fetch_stage_cla (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);
    logic [15:0] bx, g, p, c;
    assign bx = b ^ {16{sub}};
    assign g = a & bx;
    assign p = a ^ bx;
    assign c[0] = sub;
    for (genvar k = 0; k < 4; k++) begin : grp
        localparam int B = 4 * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        // the carry out of the top group would be the adder's cout, which nothing here needs
        if (k < 3) begin : nxt
            assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B]) | ((&p[B+3:B]) & c[B]);
        end
    end
    assign sum = p ^ c;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues instruction fetches, loads IF/ID, handles redirect, stall and HALT
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OPC = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_in,
    input  logic                branch_taken,
    input  logic [15:0]         branch_target,
    fetch_stage_if.master       mem,
    output logic                if_id_valid,
    output logic [15:0]         if_id_instr,
    output logic [15:0]         if_id_pc_plus_2,
    output logic                halted
);
    import fetch_stage_pkg::*;
    state_t state, state_n;
    logic [15:0] pc, pc_n, req_addr, ra_n, pc_inc;
    logic [INSTR_W-1:0] skid, skid_n, load_data;
    logic load;
    // pc equals req_addr whenever an instruction is delivered, so one incrementer serves both paths
    fetch_stage_cla u_inc (
        .a(pc),
        .b(16'd2),
        .sub(1'b0),
        .sum(pc_inc)
    );
    assign mem.req = ~rst & (state == FETCH | state == DRAIN);
    assign mem.addr = req_addr;
    assign halted = state == HALT;
    always_comb begin
        state_n = state;
        pc_n = pc;
        ra_n = req_addr;
        skid_n = skid;
        load = 1'b0;
        load_data = mem.rdata;
        case (state)
            FETCH: begin
                if (mem.ack & branch_taken) begin
                    pc_n = branch_target;
                    ra_n = branch_target;
                end else if (mem.ack & ~stall_in) begin
                    load = 1'b1;
                    pc_n = pc_inc;
                    ra_n = pc_inc;
                    state_n = is_halt(mem.rdata, HALT_OPC) ? HALT : FETCH;
                end else if (mem.ack) begin
                    skid_n = mem.rdata;
                    state_n = HOLD;
                end else if (branch_taken) begin
                    pc_n = branch_target;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                pc_n = branch_taken ? branch_target : pc;
                if (mem.ack) begin
                    ra_n = pc_n;
                    state_n = FETCH;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_n = branch_target;
                    ra_n = branch_target;
                    state_n = FETCH;
                end else if (~stall_in) begin
                    load = 1'b1;
                    load_data = skid;
                    pc_n = pc_inc;
                    ra_n = pc_inc;
                    state_n = is_halt(skid, HALT_OPC) ? HALT : FETCH;
                end
            end
            HALT: begin
                if (branch_taken) begin
                    pc_n = branch_target;
                    ra_n = branch_target;
                    state_n = FETCH;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc <= RESET_PC;
            req_addr <= RESET_PC;
            skid <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc_plus_2 <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            req_addr <= ra_n;
            skid <= skid_n;
            if (branch_taken | ~stall_in) if_id_valid <= ~branch_taken & load;
            if (load) begin
                if_id_instr <= load_data;
                if_id_pc_plus_2 <= pc_inc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus against a transaction-level fetch model with per-cycle compare
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall_in = 1'b0;
    logic branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic if_id_valid, halted;
    logic [15:0] if_id_instr, if_id_pc_plus_2;
    int n_pass = 0;
    int n_tot = 0;
    int lat = 0;
    int cnt;
    logic [15:0] mem [0:255];
    fetch_stage_if mif();
    fetch_stage dut (
        .clk(clk),
        .rst(rst),
        .stall_in(stall_in),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .mem(mif),
        .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr),
        .if_id_pc_plus_2(if_id_pc_plus_2),
        .halted(halted)
    );
    always #5 clk = ~clk;
    // memory answers lat cycles after a request appears (lat=0: same-cycle ack)
    assign mif.ack = mif.req && cnt == lat;
    assign mif.rdata = mif.ack ? mem[mif.addr[8:1]] : 16'h0000;
    always @(posedge clk or posedge rst)
        if (rst) cnt <= 0;
        else if (mif.req) cnt <= mif.ack ? 0 : cnt + 1;
    // model: the address being fetched, the architectural next pc, whether the outstanding
    // fetch is wrong-path, an instruction parked during stall, and whether HALT was fetched
    logic [15:0] m_addr, m_pc, m_skid, m_instr, m_pp2;
    logic m_wrong, m_parked, m_stop, m_valid;
    logic m_req, dlv;
    logic [15:0] dd;
    assign m_req = !rst && !m_parked && !m_stop;
    assign dlv = !branch_taken && !stall_in && (m_parked || (m_req && mif.ack && !m_wrong));
    assign dd = m_parked ? m_skid : mif.rdata;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr <= 16'h0000;
            m_pc <= 16'h0000;
            m_skid <= 16'h0000;
            m_wrong <= 1'b0;
            m_parked <= 1'b0;
            m_stop <= 1'b0;
            m_valid <= 1'b0;
            m_instr <= 16'h0000;
            m_pp2 <= 16'h0000;
        end else begin
            if (branch_taken) m_valid <= 1'b0;
            else if (!stall_in) m_valid <= dlv;
            if (dlv) begin
                m_instr <= dd;
                m_pp2 <= m_addr + 16'd2;
            end
            if (branch_taken) begin
                m_pc <= branch_target;
                m_parked <= 1'b0;
                m_stop <= 1'b0;
                if (m_req && !mif.ack) m_wrong <= 1'b1;
                else begin
                    m_addr <= branch_target;
                    m_wrong <= 1'b0;
                end
            end else if (m_req && mif.ack && m_wrong) begin
                m_wrong <= 1'b0;
                m_addr <= m_pc;
            end else if (m_req && mif.ack && stall_in) begin
                m_parked <= 1'b1;
                m_skid <= mif.rdata;
            end else if (dlv) begin
                m_pc <= m_addr + 16'd2;
                m_addr <= m_addr + 16'd2;
                m_parked <= 1'b0;
                m_stop <= dd[15:12] == 4'hF;
            end
        end
    end
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    endtask
    always @(negedge clk) begin
        chk("req", {15'b0, mif.req}, {15'b0, m_req});
        chk("addr", mif.addr, m_addr);
        chk("valid", {15'b0, if_id_valid}, {15'b0, m_valid});
        chk("instr", if_id_instr, m_instr);
        chk("pc_plus_2", if_id_pc_plus_2, m_pp2);
        chk("halted", {15'b0, halted}, {15'b0, m_stop});
    end
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[3] = 16'h1234;
        mem[8'h42] = 16'hF000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {15'b0, mif.req}, 16'h0000);
        chk("rst_addr", mif.addr, 16'h0000);
        chk("rst_valid", {15'b0, if_id_valid}, 16'h0000);
        chk("rst_pp2", if_id_pc_plus_2, 16'h0000);
        chk("rst_halted", {15'b0, halted}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("c1_req", {15'b0, mif.req}, 16'h0001);
        chk("c1_addr", mif.addr, 16'h0000);
        step();
        chk("c2_addr", mif.addr, 16'h0002);
        chk("c2_pp2", if_id_pc_plus_2, 16'h0002);
        chk("c2_valid", {15'b0, if_id_valid}, 16'h0001);
        step();
        chk("c3_addr", mif.addr, 16'h0004);
        chk("c3_pp2", if_id_pc_plus_2, 16'h0004);
        step();
        chk("c4_addr", mif.addr, 16'h0006);
        chk("c4_pp2", if_id_pc_plus_2, 16'h0006);
        stall_in = 1'b1;
        step();
        chk("hold_req", {15'b0, mif.req}, 16'h0000);
        chk("hold_instr", if_id_instr, 16'h1002);
        chk("hold_pp2", if_id_pc_plus_2, 16'h0006);
        step();
        step();
        stall_in = 1'b0;
        step();
        chk("unstall_instr", if_id_instr, 16'h1234);
        chk("unstall_addr", mif.addr, 16'h0008);
        chk("unstall_pp2", if_id_pc_plus_2, 16'h0008);
        branch_taken = 1'b1;
        branch_target = 16'h0040;
        step();
        branch_taken = 1'b0;
        chk("br_valid", {15'b0, if_id_valid}, 16'h0000);
        chk("br_addr", mif.addr, 16'h0040);
        step();
        chk("br_pp2", if_id_pc_plus_2, 16'h0042);
        chk("br_instr", if_id_instr, 16'h1020);
        lat = 3;
        branch_taken = 1'b1;
        branch_target = 16'h0080;
        step();
        branch_taken = 1'b0;
        chk("drain_addr0", mif.addr, 16'h0042);
        chk("drain_valid", {15'b0, if_id_valid}, 16'h0000);
        step();
        chk("drain_addr1", mif.addr, 16'h0042);
        step();
        chk("drain_addr2", mif.addr, 16'h0042);
        step();
        chk("drain_target", mif.addr, 16'h0080);
        chk("drain_discard", {15'b0, if_id_valid}, 16'h0000);
        lat = 0;
        step();
        chk("after_drain_pp2", if_id_pc_plus_2, 16'h0082);
        chk("after_drain_instr", if_id_instr, 16'h1040);
        step();
        step();
        chk("halt_halted", {15'b0, halted}, 16'h0001);
        chk("halt_req", {15'b0, mif.req}, 16'h0000);
        chk("halt_instr", if_id_instr, 16'hF000);
        chk("halt_valid", {15'b0, if_id_valid}, 16'h0001);
        step();
        chk("halt_bubble", {15'b0, if_id_valid}, 16'h0000);
        step();
        branch_taken = 1'b1;
        branch_target = 16'h0010;
        step();
        branch_taken = 1'b0;
        chk("unhalt_halted", {15'b0, halted}, 16'h0000);
        chk("unhalt_addr", mif.addr, 16'h0010);
        step();
        chk("unhalt_instr", if_id_instr, 16'h1008);
        branch_taken = 1'b1;
        branch_target = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        chk("wrap_addr0", mif.addr, 16'hFFFE);
        step();
        chk("wrap_addr1", mif.addr, 16'h0000);
        chk("wrap_pp2", if_id_pc_plus_2, 16'h0000);
        chk("wrap_instr", if_id_instr, 16'h10FF);
        step();
        chk("wrap_addr2", mif.addr, 16'h0002);
        lat = 3;
        step();
        chk("wait_addr", mif.addr, 16'h0002);
        rst = 1'b1;
        #1;
        chk("async_addr", mif.addr, 16'h0000);
        chk("async_req", {15'b0, mif.req}, 16'h0000);
        chk("async_valid", {15'b0, if_id_valid}, 16'h0000);
        step();
        step();
        rst = 1'b0;
        lat = 0;
        step();
        chk("rerun_pp2", if_id_pc_plus_2, 16'h0002);
        chk("rerun_valid", {15'b0, if_id_valid}, 16'h0001);
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
